// File: rtl/pg_seq_pkg.sv
// Shared types and defaults for the power-good sequencer.
// Holds the FSM state enum, the fault-code enum, default timing values
// and a small constant helper used to size the shared cycle counter.
package pg_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_RAMP_A = 3'd1,
    ST_RAMP_B = 3'd2,
    ST_SETTLE = 3'd3,
    ST_ON     = 3'd4,
    ST_SHDN_B = 3'd5,
    ST_SHDN_A = 3'd6,
    ST_FLT    = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE = 2'b00,
    FC_A    = 2'b01,
    FC_B    = 2'b10,
    FC_BOTH = 2'b11
  } fault_e;

  localparam int TIMEOUT_CYC_DEF  = 16;
  localparam int DEBOUNCE_CYC_DEF = 4;
  localparam int OFF_DLY_CYC_DEF  = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/and_pg.sv
// Two-input power-good combiner: PG is high only while both inputs are high.
// Latency: combinational.  Backpressure: none.
// Ports: A, B - power-good inputs; PG - combined power-good.
module and_pg (
  input  logic A,
  input  logic B,
  output logic PG
);

  assign PG = A & B;

endmodule

// File: rtl/pg_sequencer.sv
// Two-rail power sequencer: ramps rail A then B, debounces both goods, raises
// PG, and performs ordered B-then-A shutdown or latches a sticky fault.
// Latency: outputs are registered from next state, 1 cycle after input sample.
// Backpressure: none; all inputs are levels except the CLR_FAULT pulse.
// Ports: CLK/RST (sync, active-high); EN power-on request; A_GOOD/B_GOOD rail
//   goods; CLR_FAULT fault clear; EN_A/EN_B rail enables; PG system good;
//   FAULT/FAULT_CODE sticky fault and cause; STATE current FSM state.
module pg_sequencer
  import pg_seq_pkg::*;
#(
  parameter int TIMEOUT_CYC  = TIMEOUT_CYC_DEF,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int OFF_DLY_CYC  = OFF_DLY_CYC_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       A_GOOD,
  input  logic       B_GOOD,
  input  logic       CLR_FAULT,
  output logic       EN_A,
  output logic       EN_B,
  output logic       PG,
  output logic       FAULT,
  output logic [1:0] FAULT_CODE,
  output logic [2:0] STATE
);

  localparam int CNT_W = $clog2(max3(TIMEOUT_CYC, DEBOUNCE_CYC, OFF_DLY_CYC) + 1);

  // The counter reads k on the k-th cycle (from 0) spent in a state, so a
  // duration of N cycles expires when the counter shows N-1.
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_DLY_CYC - 1);

  state_e           state;
  state_e           state_nxt;
  fault_e           code_nxt;
  logic [CNT_W-1:0] cnt;
  logic             both_good;

  and_pg u_and_pg (
    .A  (A_GOOD),
    .B  (B_GOOD),
    .PG (both_good)
  );

  function automatic fault_e lost_code(input logic a, input logic b);
    case ({a, b})
      2'b00:   return FC_BOTH;
      2'b01:   return FC_A;
      2'b10:   return FC_B;
      default: return FC_NONE;
    endcase
  endfunction

  // Each state tests fault conditions first, then EN deassert, then progress.
  always_comb begin
    state_nxt = state;
    code_nxt  = FC_NONE;
    case (state)
      ST_OFF: begin
        if (EN) state_nxt = ST_RAMP_A;
      end
      ST_RAMP_A: begin
        if (!A_GOOD && cnt == TO_LAST) begin
          state_nxt = ST_FLT;
          code_nxt  = FC_A;
        end else if (!EN) begin
          state_nxt = ST_SHDN_A;
        end else if (A_GOOD) begin
          state_nxt = ST_RAMP_B;
        end
      end
      ST_RAMP_B: begin
        if (!A_GOOD) begin
          state_nxt = ST_FLT;
          code_nxt  = FC_A;
        end else if (!B_GOOD && cnt == TO_LAST) begin
          state_nxt = ST_FLT;
          code_nxt  = FC_B;
        end else if (!EN) begin
          state_nxt = ST_SHDN_B;
        end else if (B_GOOD) begin
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // Any drop leaves the state, so the counter doubles as the
        // consecutive-both-good count.
        if (!both_good) begin
          state_nxt = ST_FLT;
          code_nxt  = lost_code(A_GOOD, B_GOOD);
        end else if (!EN) begin
          state_nxt = ST_SHDN_B;
        end else if (cnt == DB_LAST) begin
          state_nxt = ST_ON;
        end
      end
      ST_ON: begin
        if (!both_good) begin
          state_nxt = ST_FLT;
          code_nxt  = lost_code(A_GOOD, B_GOOD);
        end else if (!EN) begin
          state_nxt = ST_SHDN_B;
        end
      end
      // Shutdown ignores goods and EN; it always runs through to OFF.
      ST_SHDN_B: begin
        if (cnt == OFF_LAST) state_nxt = ST_SHDN_A;
      end
      ST_SHDN_A: begin
        if (cnt == OFF_LAST) state_nxt = ST_OFF;
      end
      ST_FLT: begin
        if (CLR_FAULT && !EN) state_nxt = ST_OFF;
      end
      default: state_nxt = ST_OFF;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_OFF;
      cnt        <= '0;
      EN_A       <= 1'b0;
      EN_B       <= 1'b0;
      PG         <= 1'b0;
      FAULT      <= 1'b0;
      FAULT_CODE <= FC_NONE;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
      EN_A  <= (state_nxt inside {ST_RAMP_A, ST_RAMP_B, ST_SETTLE, ST_ON, ST_SHDN_B});
      EN_B  <= (state_nxt inside {ST_RAMP_B, ST_SETTLE, ST_ON});
      PG    <= (state_nxt == ST_ON);
      FAULT <= (state_nxt == ST_FLT);
      // Code is captured only on the entering edge and held while in FLT.
      if (state_nxt != ST_FLT) begin
        FAULT_CODE <= FC_NONE;
      end else if (state != ST_FLT) begin
        FAULT_CODE <= code_nxt;
      end
    end
  end

  assign STATE = state;

endmodule
